// File: rtl/fusion_result_accumulator.sv
// Saturating lane accumulator for packed fusion-unit product words.
// A job sums len words into 1, 2 or 4 lanes and holds the result until taken.
module fusion_result_accumulator (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   cfga,
  input  logic [1:0]   cfgb,
  input  logic         signed_mode,
  input  logic [7:0]   len,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic [2:0]   res_lanes,
  output logic [3:0]   res_ovf,
  output logic         busy,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             legal;
  logic [2:0]       lanes_new;
  logic             launch;
  logic             accept;
  logic             last;

  logic             sgn;
  logic [7:0]       len_q;
  logic [7:0]       cnt;
  logic [2:0]       lanes_q;
  logic [3:0][31:0] acc;
  logic [3:0]       ovf;
  logic             err_q;

  logic [3:0][31:0] lane;
  logic [3:0]       act;
  logic [3:0][32:0] sum;

  assign legal  = (cfga != 2'b11) && (cfgb != 2'b11);
  assign launch = (state == IDLE) && start && legal;
  assign accept = in_valid && in_ready;
  assign last   = accept && ((cnt + 8'd1) == len_q);

  always_comb begin
    case ({cfga, cfgb})
      4'b1010:          lanes_new = 3'd1;
      4'b1001, 4'b0110: lanes_new = 3'd2;
      default:          lanes_new = 3'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = ACC;
      ACC:  if (len_q == 8'd0 || last) state_nxt = HOLD;
      HOLD: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero-length job never raises in_ready, so no word is consumed.
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ACC: begin
        in_ready = (cnt != len_q);
        busy     = 1'b1;
      end
      HOLD: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane = '0;
    act  = 4'b0000;
    case (lanes_q)
      3'd1: begin
        lane[0] = in_data[31:0];
        act     = 4'b0001;
      end
      3'd2: begin
        lane[0] = in_data[31:0];
        lane[1] = in_data[63:32];
        act     = 4'b0011;
      end
      3'd4: begin
        for (int k = 0; k < 4; k++)
          lane[k] = {{16{sgn & in_data[16*k+15]}},
                     in_data[16*k +: 16]};
        act = 4'b1111;
      end
      default: ;
    endcase
  end

  // One guard bit catches both signed and unsigned overflow.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (sgn)
        sum[k] = {acc[k][31], acc[k]} + {lane[k][31], lane[k]};
      else
        sum[k] = {1'b0, acc[k]} + {1'b0, lane[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn     <= 1'b0;
      len_q   <= 8'd0;
      lanes_q <= 3'd0;
      cnt     <= 8'd0;
      acc     <= '0;
      ovf     <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !legal;
      if (launch) begin
        sgn     <= signed_mode;
        len_q   <= len;
        lanes_q <= lanes_new;
        cnt     <= 8'd0;
        acc     <= '0;
        ovf     <= 4'b0000;
      end else if (accept) begin
        cnt <= cnt + 8'd1;
        for (int k = 0; k < 4; k++) begin
          if (act[k]) begin
            if (sgn && (sum[k][32] != sum[k][31])) begin
              acc[k] <= sum[k][32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
              ovf[k] <= 1'b1;
            end else if (!sgn && sum[k][32]) begin
              acc[k] <= 32'hFFFF_FFFF;
              ovf[k] <= 1'b1;
            end else begin
              acc[k] <= sum[k][31:0];
            end
          end
        end
      end
    end
  end

  assign res_data  = acc;
  assign res_lanes = lanes_q;
  assign res_ovf   = ovf;
  assign cfg_err   = err_q;

endmodule
